// File: rtl/float_struct.sv
// Shared floating-point type definitions.
//   float_point_num : IEEE-754 single-precision layout {sign, exp, mant}
//   operand_pair_t  : one adder operation, operand A in the upper word
package float_struct;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_point_num;

  typedef struct packed {
    float_point_num a;
    float_point_num b;
  } operand_pair_t;

endpackage

// File: rtl/fpu_add_issue_if.sv
// Producer-side operand handshake for fpu_add_issue.
//   in_a, in_b : operand pair offered by the producer
//   in_vld     : producer has a valid pair
//   in_rdy     : issue stage accepts the pair this cycle
// master = producer, slave = issue stage.
interface fpu_add_issue_if;
  import float_struct::*;

  float_point_num in_a;
  float_point_num in_b;
  logic           in_vld;
  logic           in_rdy;

  modport master (output in_a, output in_b, output in_vld, input in_rdy);
  modport slave  (input in_a, input in_b, input in_vld, output in_rdy);

endinterface

// File: rtl/fpu_add_issue_fifo.sv
// fpu_pair_fifo: DEPTH-entry synchronous FIFO of operand pairs.
//   clk, rst  : clock, asynchronous active-high reset (control only)
//   push      : write push_data at the tail (ignored when full or flushing)
//   pop       : drop the head entry (ignored when empty or flushing)
//   flush     : discard every queued entry at this edge
//   push_data : pair to write
//   head      : pair at the head of the queue
//   count     : number of queued pairs
// Full/empty come from count, so the pointers may wrap freely.
module fpu_pair_fifo
  import float_struct::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  operand_pair_t                push_data,
  output operand_pair_t                head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  operand_pair_t      mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok;
  logic               pop_ok;

  always_comb begin
    push_ok  = push && (count_q != CNT_W'(DEPTH)) && !flush;
    pop_ok   = pop && (count_q != '0) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; its contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fpu_add_issue.sv
// fpu_add_issue: operand issue stage in front of floating_point_adder.
// Queues operand pairs and issues one per cycle to the adder, but only while
// a downstream result-buffer credit is available, since the adder cannot stall.
//   clk, rst    : clock, asynchronous active-high reset
//   in_if       : producer handshake (in_a, in_b, in_vld, in_rdy)
//   flush       : discard queued, not-yet-issued pairs
//   credit_ret  : one result-buffer slot freed (one-cycle pulse)
//   a, b        : registered operands to the adder
//   arg_vld     : registered one-cycle pulse per issued pair
//   fifo_count  : queued pairs
//   credit_cnt  : available credits
//   credit_err  : sticky, a credit came back while already at CREDITS
module fpu_add_issue
  import float_struct::*;
#(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  fpu_add_issue_if.slave                 in_if,
  input  logic                           flush,
  input  logic                           credit_ret,
  output float_point_num                 a,
  output float_point_num                 b,
  output logic                           arg_vld,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
  output logic [$clog2(CREDITS+1)-1:0]   credit_cnt,
  output logic                           credit_err
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int CR_W  = $clog2(CREDITS+1);

  operand_pair_t    head;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             issue;

  float_point_num   a_q, a_d;
  float_point_num   b_q, b_d;
  logic             arg_vld_q, arg_vld_d;
  logic [CR_W-1:0]  credit_q, credit_d;
  logic             credit_err_q, credit_err_d;

  // Ready depends only on occupancy: no push into a full queue even when the
  // head is leaving on the same edge.
  assign in_if.in_rdy = !rst && (count != CNT_W'(DEPTH));
  assign push         = in_if.in_vld && in_if.in_rdy;
  assign issue        = (count != '0) && (credit_q != '0) && !flush;

  fpu_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (issue),
    .flush     (flush),
    .push_data ({in_if.in_a, in_if.in_b}),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    arg_vld_d    = issue;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    if (issue) begin
      a_d = head.a;
      b_d = head.b;
    end
    case ({issue, credit_ret})
      2'b10: credit_d = credit_q - CR_W'(1);
      2'b01: begin
        // A return with every slot already free means the consumer is out of
        // step with us; saturate and latch the error.
        if (credit_q == CR_W'(CREDITS)) credit_err_d = 1'b1;
        else                            credit_d     = credit_q + CR_W'(1);
      end
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      arg_vld_q    <= 1'b0;
      credit_q     <= CR_W'(CREDITS);
      credit_err_q <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      arg_vld_q    <= arg_vld_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign arg_vld    = arg_vld_q;
  assign fifo_count = count;
  assign credit_cnt = credit_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_fpu_add_issue.sv
module tb_fpu_add_issue;
  import float_struct::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        credit_ret;
  logic [31:0] a_o, b_o;
  logic        arg_vld;
  logic [2:0]  fifo_count;
  logic [3:0]  credit_cnt;
  logic        credit_err;

  fpu_add_issue_if pif ();

  fpu_add_issue #(.DEPTH(4), .CREDITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (pif),
    .flush      (flush),
    .credit_ret (credit_ret),
    .a          (a_o),
    .b          (b_o),
    .arg_vld    (arg_vld),
    .fifo_count (fifo_count),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] ia;
    logic [31:0] ib;
    logic        ret;
    logic        fl;
    logic        e_vld;
    logic [31:0] ea;
    logic [31:0] eb;
    int          ef;
    int          ec;
    logic        erdy;
    logic        eerr;
  } vec_t;

  vec_t        tv [13];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_issue = 0;
  bit          mon_en  = 0;
  logic [63:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: record what the edge accepts, then sample at the falling edge.
  task automatic tick();
    logic acc;
    acc = pif.in_vld && pif.in_rdy && !rst;
    if (flush)    sb.delete();
    else if (acc) sb.push_back({pif.in_a, pif.in_b});
    @(posedge clk);
    @(negedge clk);
    if (mon_en && arg_vld) begin
      n_issue++;
      if (sb.size() == 0) begin
        chk("unexpected_issue", 32'(arg_vld), 32'd0);
      end else begin
        chk("issue_a", a_o, sb[0][63:32]);
        chk("issue_b", b_o, sb[0][31:0]);
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic put(input logic v, input logic [31:0] ia, input logic [31:0] ib);
    pif.in_vld = v;
    pif.in_a   = ia;
    pif.in_b   = ib;
  endtask

  initial begin
    int pushed;
    rst        = 1'b1;
    flush      = 1'b0;
    credit_ret = 1'b0;
    put(1'b0, 32'h0, 32'h0);

    // Vectors: inputs applied before an edge, expectations after it.
    //            vld   in_a          in_b          ret   fl    e_vld ea            eb            f  c  rdy   err
    tv[0]  = '{1'b1, 32'h3F8F5C29, 32'h4094CCCD, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1, 8, 1'b1, 1'b0};
    tv[1]  = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h3F8F5C29, 32'h4094CCCD, 0, 7, 1'b1, 1'b0};
    tv[2]  = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h3F8F5C29, 32'h4094CCCD, 0, 7, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 32'h40490FDB, 32'hC0490FDB, 1'b0, 1'b0, 1'b0, 32'h3F8F5C29, 32'h4094CCCD, 1, 7, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 32'h40490FDB, 32'hC0490FDB, 1, 6, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 32'h7F800000, 32'hFF800000, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h80000000, 1, 5, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 32'h7F800000, 32'hFF800000, 0, 5, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h7F800000, 32'hFF800000, 0, 5, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h7F800000, 32'hFF800000, 0, 6, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h7F800000, 32'hFF800000, 0, 7, 1'b1, 1'b0};
    tv[10] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h7F800000, 32'hFF800000, 0, 8, 1'b1, 1'b0};
    tv[11] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h7F800000, 32'hFF800000, 0, 8, 1'b1, 1'b1};
    tv[12] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h7F800000, 32'hFF800000, 0, 8, 1'b1, 1'b1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_arg_vld", 32'(arg_vld), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_credit_cnt", 32'(credit_cnt), 32'd8);
    chk("rst_in_rdy", 32'(pif.in_rdy), 32'd0);
    chk("rst_credit_err", 32'(credit_err), 32'd0);
    chk("rst_a", a_o, 32'h0);
    rst = 1'b0;
    #1 chk("rel_in_rdy", 32'(pif.in_rdy), 32'd1);
    @(negedge clk);

    // Table: single pair latency, back-to-back issue, issue+return at 5,
    // credit refill and overflow return.
    for (int i = 0; i < 13; i++) begin
      put(tv[i].vld, tv[i].ia, tv[i].ib);
      credit_ret = tv[i].ret;
      flush      = tv[i].fl;
      tick();
      chk($sformatf("v%0d_arg_vld", i), 32'(arg_vld), 32'(tv[i].e_vld));
      chk($sformatf("v%0d_a", i), a_o, tv[i].ea);
      chk($sformatf("v%0d_b", i), b_o, tv[i].eb);
      chk($sformatf("v%0d_fifo_count", i), 32'(fifo_count), 32'(tv[i].ef));
      chk($sformatf("v%0d_credit_cnt", i), 32'(credit_cnt), 32'(tv[i].ec));
      chk($sformatf("v%0d_in_rdy", i), 32'(pif.in_rdy), 32'(tv[i].erdy));
      chk($sformatf("v%0d_credit_err", i), 32'(credit_err), 32'(tv[i].eerr));
    end
    put(1'b0, 32'h0, 32'h0);
    credit_ret = 1'b0;

    // Fill with credits blocked: 12 pairs, 8 issue, 4 stay queued.
    mon_en = 1;
    sb.delete();
    n_issue = 0;
    pushed  = 0;
    for (int cyc = 0; cyc < 40 && pushed < 12; cyc++) begin
      put(1'b1, 32'h40000000 + 32'(pushed), 32'hC0000000 + 32'(pushed));
      if (pif.in_rdy) pushed++;
      tick();
    end
    put(1'b0, 32'h0, 32'h0);
    chk("fill_pushed", 32'(pushed), 32'd12);
    chk("fill_fifo_count", 32'(fifo_count), 32'd4);
    chk("fill_credit_cnt", 32'(credit_cnt), 32'd0);
    chk("fill_in_rdy", 32'(pif.in_rdy), 32'd0);
    chk("fill_issues", 32'(n_issue), 32'd8);
    tick();
    tick();
    chk("blocked_issues", 32'(n_issue), 32'd8);

    // Three back-to-back returns release exactly three pairs.
    credit_ret = 1'b1;
    tick();
    tick();
    tick();
    credit_ret = 1'b0;
    tick();
    tick();
    chk("ret3_issues", 32'(n_issue), 32'd11);
    chk("ret3_fifo_count", 32'(fifo_count), 32'd1);
    chk("ret3_credit_cnt", 32'(credit_cnt), 32'd0);

    // Push and pop on the same edge at fifo_count=2.
    put(1'b1, 32'h41200000, 32'h3DCCCCCD);
    tick();
    put(1'b0, 32'h0, 32'h0);
    chk("pp_pre_count", 32'(fifo_count), 32'd2);
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    chk("pp_pre_credit", 32'(credit_cnt), 32'd1);
    put(1'b1, 32'h41A00000, 32'hBF800000);
    tick();
    put(1'b0, 32'h0, 32'h0);
    chk("pp_count", 32'(fifo_count), 32'd2);
    chk("pp_arg_vld", 32'(arg_vld), 32'd1);
    chk("pp_credit", 32'(credit_cnt), 32'd0);

    // Flush with 3 queued and a credit available; the same-cycle push is lost.
    put(1'b1, 32'h42C80000, 32'h3F000000);
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    chk("fl_pre_count", 32'(fifo_count), 32'd3);
    chk("fl_pre_credit", 32'(credit_cnt), 32'd1);
    put(1'b1, 32'h12345678, 32'h9ABCDEF0);
    flush = 1'b1;
    chk("fl_in_rdy", 32'(pif.in_rdy), 32'd1);
    tick();
    flush = 1'b0;
    chk("fl_count", 32'(fifo_count), 32'd0);
    chk("fl_arg_vld", 32'(arg_vld), 32'd0);
    chk("fl_credit", 32'(credit_cnt), 32'd1);
    put(1'b1, 32'h3E800000, 32'hC1100000);
    tick();
    put(1'b0, 32'h0, 32'h0);
    chk("fl_next_count", 32'(fifo_count), 32'd1);
    tick();
    chk("fl_next_vld", 32'(arg_vld), 32'd1);
    chk("fl_next_a", a_o, 32'h3E800000);
    chk("fl_next_b", b_o, 32'hC1100000);
    chk("fl_next_credit", 32'(credit_cnt), 32'd0);

    // Async reset mid-stream: two queued, one just issued.
    put(1'b1, 32'h3F800001, 32'h3F800002);
    tick();
    put(1'b1, 32'h3F800003, 32'h3F800004);
    tick();
    put(1'b0, 32'h0, 32'h0);
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    put(1'b1, 32'h3F800005, 32'h3F800006);
    tick();
    put(1'b0, 32'h0, 32'h0);
    chk("mid_count", 32'(fifo_count), 32'd2);
    chk("mid_arg_vld", 32'(arg_vld), 32'd1);
    chk("mid_credit_err", 32'(credit_err), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_arg_vld", 32'(arg_vld), 32'd0);
    chk("arst_fifo_count", 32'(fifo_count), 32'd0);
    chk("arst_credit_cnt", 32'(credit_cnt), 32'd8);
    chk("arst_in_rdy", 32'(pif.in_rdy), 32'd0);
    chk("arst_credit_err", 32'(credit_err), 32'd0);
    chk("arst_a", a_o, 32'h0);
    chk("arst_b", b_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1 chk("post_in_rdy", 32'(pif.in_rdy), 32'd1);
    @(negedge clk);
    put(1'b1, 32'hBF8F5C29, 32'h4094CCCD);
    tick();
    put(1'b0, 32'h0, 32'h0);
    tick();
    chk("post_arg_vld", 32'(arg_vld), 32'd1);
    chk("post_a", a_o, 32'hBF8F5C29);
    chk("post_credit", 32'(credit_cnt), 32'd7);
    chk("post_leftover", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
